// File: rtl/io_input_conditioner.sv
// Purpose : synchronize, polarity-correct and debounce raw board inputs into the
//           In_devices vector; selected channels become sticky rising-edge flags
//           that are cleared when the processor reads that channel's I/O address.
// Latency : raw change stable before edge N reaches db at edge N+1+DB_CYCLES;
//           edge_pulse one edge later; sticky flag one edge after edge_pulse.
// Backpressure: none; flags hold events until rd_ack addresses the channel.
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   raw_in     - asynchronous board pins, one per channel
//   rd_ack     - one-cycle pulse, processor completed an I/O read
//   rd_adr     - channel index of that read (indices >= NUM_CH ignored)
//   In_devices - conditioned level (or sticky flag for latched channels)
//   edge_pulse - one-cycle strobe per debounced 0->1 transition
module io_input_conditioner #(
  parameter int                NUM_CH          = 32,
  parameter int                DB_CYCLES       = 500000,
  parameter int                CNT_W           = 19,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0,
  parameter logic [NUM_CH-1:0] LATCH_MASK      = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic              rd_ack,
  input  logic [4:0]        rd_adr,
  output logic [NUM_CH-1:0] In_devices,
  output logic [NUM_CH-1:0] edge_pulse
);

  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [NUM_CH-1:0] ONE_HOT = NUM_CH'(1);

  logic [NUM_CH-1:0] s1_q, s2_q;
  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] db_q, db_d;
  logic [NUM_CH-1:0] db_dly_q;
  logic [NUM_CH-1:0] edge_q, edge_d;
  logic [NUM_CH-1:0] flag_q, flag_d;
  logic [NUM_CH-1:0] clr;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  // Synchronized pins corrected so that 1 always means "active".
  assign lvl = s2_q ^ ACTIVE_LOW_MASK;

  // A read address beyond the channel count shifts the bit out entirely.
  assign clr = rd_ack ? (ONE_HOT << rd_adr) : '0;

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (lvl[i] == db_q[i]) begin
        // Any return to the accepted level restarts the persistence count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = lvl[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Delayed copy of db gives a registered rising-edge strobe.
  assign edge_d = db_q & ~db_dly_q;

  // Set has priority over clear so an edge landing on the read is not lost.
  assign flag_d = (LATCH_MASK & edge_q) | (flag_q & ~clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= ACTIVE_LOW_MASK;
      s2_q     <= ACTIVE_LOW_MASK;
      db_q     <= '0;
      db_dly_q <= '0;
      edge_q   <= '0;
      flag_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw_in;
      s2_q     <= s1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      edge_q   <= edge_d;
      flag_q   <= flag_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pure register selection; the mask is a constant so no logic path from inputs.
  assign In_devices = (LATCH_MASK & flag_q) | (~LATCH_MASK & db_q);
  assign edge_pulse = edge_q;

endmodule
